// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
// Holds the FSM state type, counter sizing and legal parameter limits.
package debounce_pkg;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int DEB_MIN  = 1;

  function automatic int cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Plain flop synchronizer for an asynchronous input.
// Stages only shift; nothing sits between them.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift din through the chain, preset to RESET_VAL on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw input into a clean level plus rise/fall pulses.
// q flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
    end
    if (DEBOUNCE_CYCLES < DEB_MIN) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  // stability FSM: count disagreeing samples, flip q on the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        STABLE: begin
          cnt <= '0;
          if (s != q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              q    <= s;
              rise <= s;
              fall <= ~s;
            end else begin
              cnt   <= CNT_ONE;
              state <= COUNTING;
              busy  <= 1'b1;
            end
          end
        end
        COUNTING: begin
          if (s == q) begin
            cnt   <= '0;
            state <= STABLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            q     <= s;
            rise  <= s;
            fall  <= ~s;
            cnt   <= '0;
            state <= STABLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
